// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: access sizes, FSM states,
// RAM size masks and the latched request control word.
package lsu_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned MASK_WIDTH = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  localparam logic [MASK_WIDTH-1:0] MASK_BYTE = 4'b0001;
  localparam logic [MASK_WIDTH-1:0] MASK_HALF = 4'b0011;
  localparam logic [MASK_WIDTH-1:0] MASK_WORD = 4'b1111;
  localparam logic [MASK_WIDTH-1:0] MASK_NONE = 4'b0000;

  // Control fields of an accepted request, held until its response.
  typedef struct packed {
    logic  write;
    size_e size;
    logic  sext;
    logic  err;
  } req_ctl_t;

  function automatic logic [MASK_WIDTH-1:0] size_mask(input size_e size);
    case (size)
      SZ_BYTE: size_mask = MASK_BYTE;
      SZ_HALF: size_mask = MASK_HALF;
      SZ_WORD: size_mask = MASK_WORD;
      default: size_mask = MASK_NONE;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of right-justified RAM read data to 32 bits.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  size_e                  size,
  input  logic                   sext,
  input  logic [DATA_WIDTH-1:0]  raw,
  output logic [DATA_WIDTH-1:0]  ext_c
);

  always_comb begin
    ext_c = raw;
    case (size)
      SZ_BYTE: ext_c = {{24{sext & raw[7]}}, raw[7:0]};
      SZ_HALF: ext_c = {{16{sext & raw[15]}}, raw[15:0]};
      default: ext_c = raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store initiator for a big-endian byte-addressed RAM.
// Define LSU_ALIGN_CHECK_EN to reject misaligned half/word accesses instead of aligning them.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 13
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [1:0]             req_size,
  input  logic                   req_signed,
  input  logic [31:0]            req_addr,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  output logic                   resp_valid,
  output logic                   resp_err,
  output logic [DATA_WIDTH-1:0]  resp_rdata,
  output logic                   mem_writeEn,
  output logic [MASK_WIDTH-1:0]  mem_mMask,
  output logic [ADDR_WIDTH-1:0]  mem_writeAddr,
  output logic [ADDR_WIDTH-1:0]  mem_readAddr,
  output logic [DATA_WIDTH-1:0]  mem_writeData,
  input  logic [DATA_WIDTH-1:0]  mem_readData
);

  state_e                 state_q, state_d;
  req_ctl_t               ctl_q, ctl_d;
  logic                   req_ready_q, req_ready_d;
  logic                   resp_valid_q, resp_valid_d;
  logic                   resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   mem_we_q, mem_we_d;
  logic [MASK_WIDTH-1:0]  mem_mask_q, mem_mask_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;

  size_e                  req_size_e;
  logic [ADDR_WIDTH-1:0]  eff_addr;
  logic                   misaligned;
  logic                   req_err;
  logic [DATA_WIDTH-1:0]  load_ext;

  assign req_size_e = size_e'(req_size);

  // Request legality and the RAM address actually used.
  always_comb begin
    eff_addr   = req_addr[ADDR_WIDTH-1:0];
    misaligned = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
    misaligned = ((req_size_e == SZ_HALF) && req_addr[0]) ||
                 ((req_size_e == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    if (req_size_e == SZ_HALF) eff_addr[0] = 1'b0;
    if (req_size_e == SZ_WORD) eff_addr[1:0] = 2'b00;
`endif
    req_err = (req_size_e == SZ_RSVD) ||
              ((req_addr >> ADDR_WIDTH) != 32'd0) ||
              misaligned;
  end

  lsu_load_extend u_load_extend (
    .size  (ctl_q.size),
    .sext  (ctl_q.sext),
    .raw   (mem_readData),
    .ext_c (load_ext)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_d      = state_q;
    ctl_d        = ctl_q;
    mem_we_d     = 1'b0;
    mem_mask_d   = MASK_NONE;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rdata_d      = rdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          ctl_d.write = req_write;
          ctl_d.size  = req_size_e;
          ctl_d.sext  = req_signed;
          ctl_d.err   = req_err;
          // A rejected request still spends one cycle here, just without the RAM.
          state_d     = ST_ACCESS;
          if (!req_err) begin
            mem_we_d    = req_write;
            mem_mask_d  = size_mask(req_size_e);
            mem_addr_d  = eff_addr;
            mem_wdata_d = req_wdata;
          end
        end
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        rdata_d = (ctl_q.err || ctl_q.write) ? '0 : load_ext;
      end
      ST_RESP: begin
        state_d      = ST_IDLE;
        resp_valid_d = 1'b1;
        resp_err_d   = ctl_q.err;
      end
      default: state_d = ST_IDLE;
    endcase

    req_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ctl_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rdata_q      <= '0;
      mem_we_q     <= 1'b0;
      mem_mask_q   <= MASK_NONE;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      ctl_q        <= ctl_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      rdata_q      <= rdata_d;
      mem_we_q     <= mem_we_d;
      mem_mask_q   <= mem_mask_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_err      = resp_err_q;
  assign resp_rdata    = rdata_q;
  assign mem_writeEn   = mem_we_q;
  assign mem_mMask     = mem_mask_q;
  assign mem_writeAddr = mem_addr_q;
  assign mem_readAddr  = mem_addr_q;
  assign mem_writeData = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit with a big-endian RAM model
// and a transaction-level reference memory.
module tb_load_store_unit;

  localparam int unsigned AW    = 13;
  localparam int unsigned DEPTH = 1 << AW;
`ifdef LSU_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_err;
  logic [31:0]   resp_rdata;
  logic          mem_writeEn;
  logic [3:0]    mem_mMask;
  logic [AW-1:0] mem_writeAddr;
  logic [AW-1:0] mem_readAddr;
  logic [31:0]   mem_writeData;
  logic [31:0]   mem_readData;

  int checks   = 0;
  int failures = 0;

  logic [7:0] ram     [DEPTH];
  logic [7:0] ref_mem [DEPTH];
  logic       clear_ram;

  load_store_unit #(.ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_size      (req_size),
    .req_signed    (req_signed),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_err      (resp_err),
    .resp_rdata    (resp_rdata),
    .mem_writeEn   (mem_writeEn),
    .mem_mMask     (mem_mMask),
    .mem_writeAddr (mem_writeAddr),
    .mem_readAddr  (mem_readAddr),
    .mem_writeData (mem_writeData),
    .mem_readData  (mem_readData)
  );

  always #5 clk = ~clk;

  function automatic int mask_bytes(input logic [3:0] m);
    case (m)
      4'b0001: return 1;
      4'b0011: return 2;
      4'b1111: return 4;
      default: return 0;
    endcase
  endfunction

  // RAM: combinational big-endian read, write committed on the falling edge.
  always_comb begin
    mem_readData = '0;
    for (int i = 0; i < mask_bytes(mem_mMask); i++)
      mem_readData = (mem_readData << 8) | 32'(ram[(int'(mem_readAddr) + i) % DEPTH]);
  end

  always @(negedge clk) begin
    if (clear_ram) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= 8'h00;
    end else if (mem_writeEn) begin
      for (int i = 0; i < mask_bytes(mem_mMask); i++)
        ram[(int'(mem_writeAddr) + i) % DEPTH] <=
          8'(mem_writeData >> (8 * (mask_bytes(mem_mMask) - 1 - i)));
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_rvalid"}, 32'(resp_valid), 32'd0);
    check({tag, "_rerr"}, 32'(resp_err), 32'd0);
    check({tag, "_rdata"}, resp_rdata, 32'd0);
    check({tag, "_we"}, 32'(mem_writeEn), 32'd0);
    check({tag, "_mask"}, 32'(mem_mMask), 32'd0);
    check({tag, "_waddr"}, 32'(mem_writeAddr), 32'd0);
    check({tag, "_raddr"}, 32'(mem_readAddr), 32'd0);
    check({tag, "_wdata"}, mem_writeData, 32'd0);
  endtask

  // One request end to end; called and returning in the low phase of the clock.
  task automatic do_req(input string tag, input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input bit hold, input bit expect_immediate);
    int          n;
    int          eff;
    int          waits;
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [3:0]  exp_mask;

    n       = 1 << sz;
    exp_err = (sz == 2'd3) || (addr >= 32'(DEPTH)) || (ALIGN && ((addr % 32'(n)) != 0));
    eff     = int'(addr % 32'(DEPTH));
    eff     = eff - (eff % n);
    exp_mask = exp_err ? 4'b0000 : 4'((1 << n) - 1);
    exp_rd  = '0;
    if (!exp_err) begin
      if (w) begin
        for (int i = 0; i < n; i++) ref_mem[eff + i] = 8'(wd >> (8 * (n - 1 - i)));
      end else begin
        for (int i = 0; i < n; i++) exp_rd = (exp_rd << 8) | 32'(ref_mem[eff + i]);
        if (sx && n < 4 && exp_rd[8 * n - 1]) exp_rd = exp_rd | ~((32'd1 << (8 * n)) - 32'd1);
      end
    end

    req_write  = w;
    req_size   = sz;
    req_signed = sx;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid  = 1'b1;

    waits = 0;
    while (!req_ready) begin
      @(negedge clk);
      waits++;
      if (waits > 20) begin
        check({tag, "_accept_timeout"}, 32'(waits), 32'd0);
        req_valid = 1'b0;
        return;
      end
    end
    if (expect_immediate) check({tag, "_b2b_wait"}, 32'(waits), 32'd0);

    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;

    // Access cycle.
    @(negedge clk);
    check({tag, "_acc_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_acc_rvalid"}, 32'(resp_valid), 32'd0);
    check({tag, "_acc_we"}, 32'(mem_writeEn), 32'(w && !exp_err));
    check({tag, "_acc_mask"}, 32'(mem_mMask), 32'(exp_mask));
    if (!exp_err) begin
      check({tag, "_acc_waddr"}, 32'(mem_writeAddr), 32'(eff));
      check({tag, "_acc_raddr"}, 32'(mem_readAddr), 32'(eff));
      check({tag, "_acc_wdata"}, mem_writeData, wd);
    end

    // Response-state cycle.
    @(negedge clk);
    check({tag, "_rs_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_rs_rvalid"}, 32'(resp_valid), 32'd0);
    check({tag, "_rs_we"}, 32'(mem_writeEn), 32'd0);

    // Response strobe, two edges after acceptance.
    @(negedge clk);
    check({tag, "_rvalid"}, 32'(resp_valid), 32'd1);
    check({tag, "_rerr"}, 32'(resp_err), 32'(exp_err));
    check({tag, "_rdata"}, resp_rdata, exp_rd);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_mask_idle"}, 32'(mem_mMask), 32'd0);
  endtask

  task automatic random_req(input int idx, input bit hold, input bit imm);
    logic [31:0] a;
    logic [1:0]  s;
    a = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 63));
    s = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    do_req($sformatf("rnd%0d", idx), 1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)),
           a, $urandom, hold, imm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    clear_ram  = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'd0;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;

    @(negedge clk);
    check_reset_values("reset");
    @(negedge clk);
    rst       = 1'b0;
    clear_ram = 1'b0;
    @(negedge clk);

    do_req("sw10",  1'b1, 2'd2, 1'b0, 32'h10,   32'h11223344, 1'b0, 1'b0);
    do_req("lw10",  1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        1'b0, 1'b1);
    do_req("lbu13", 1'b0, 2'd0, 1'b0, 32'h13,   32'h0,        1'b0, 1'b1);
    do_req("sb21",  1'b1, 2'd0, 1'b0, 32'h21,   32'h80,       1'b0, 1'b1);
    do_req("lb21",  1'b0, 2'd0, 1'b1, 32'h21,   32'h0,        1'b0, 1'b1);
    do_req("lbu21", 1'b0, 2'd0, 1'b0, 32'h21,   32'h0,        1'b0, 1'b1);
    do_req("sh40",  1'b1, 2'd1, 1'b0, 32'h40,   32'hBEEF,     1'b0, 1'b1);
    do_req("lh40",  1'b0, 2'd1, 1'b1, 32'h40,   32'h0,        1'b0, 1'b1);
    do_req("lhu40", 1'b0, 2'd1, 1'b0, 32'h40,   32'h0,        1'b0, 1'b1);
    do_req("lbu41", 1'b0, 2'd0, 1'b0, 32'h41,   32'h0,        1'b0, 1'b1);
    do_req("rsvd",  1'b0, 2'd3, 1'b0, 32'h10,   32'h0,        1'b0, 1'b1);
    do_req("oorsw", 1'b1, 2'd2, 1'b0, 32'h2000, 32'hDEADBEEF, 1'b0, 1'b1);
    do_req("lw10b", 1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        1'b0, 1'b1);
    do_req("lw12",  1'b0, 2'd2, 1'b0, 32'h12,   32'h0,        1'b0, 1'b1);
    do_req("lwtop", 1'b1, 2'd2, 1'b0, 32'h1FFC, 32'hCAFEF00D, 1'b0, 1'b1);
    do_req("lwtop2",1'b0, 2'd2, 1'b0, 32'h1FFC, 32'h0,        1'b0, 1'b1);

    // Back-to-back with req_valid held high throughout.
    for (int i = 0; i < 8; i++) random_req(100 + i, 1'b1, 1'b1);
    req_valid = 1'b0;
    @(negedge clk);

    // Reset pulse during the access cycle of a load.
    req_write  = 1'b0;
    req_size   = 2'd2;
    req_signed = 1'b0;
    req_addr   = 32'h10;
    req_valid  = 1'b1;
    check("mid_pre_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    #1;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("midrst");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("midrst_noresp%0d", i), 32'(resp_valid), 32'd0);
      check($sformatf("midrst_ready%0d", i), 32'(req_ready), 32'd1);
    end

    for (int i = 0; i < 40; i++) random_req(i, 1'b0, 1'b0);
    for (int i = 0; i < 64; i += 4)
      do_req($sformatf("sweep%0d", i), 1'b0, 2'd2, 1'b0, 32'(i), 32'h0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
